inv_addkey_mixcol_stage: RTL and testbench
==========================================

INV_ADDKEY_MIXCOL_STAGE -- requirements
Module: inv_addkey_mixcol_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be, in this order:
- `clk`, input, 1 bit: rising-edge clock.
- `rst`, input, 1 bit: synchronous active-high reset.
- `in_valid`, input, 1 bit: an input beat is offered.
- `in_ready`, output, 1 bit: the stage can accept a beat.
- `in_state`, input, 128 bits: state after InvSubBytes+InvShiftRows.
- `in_key`, input, 128 bits: round key for this beat.
- `in_last`, input, 1 bit: final decryption round; InvMixColumns is bypassed.
- `out_valid`, output, 1 bit: an output beat is present.
- `out_ready`, input, 1 bit: the consumer accepts the beat.
- `out_state`, output, 128 bits: processed state.
- `out_last`, output, 1 bit: `in_last` carried with the beat.
- `blk_cnt`, output, 16 bits: count of completed output handshakes.

Function
REQ-003 Byte order SHALL be: byte k = `state[127-8k -: 8]`; column c = bytes 4c..4c+3, with byte 4c in row 0.
REQ-004 An input handshake SHALL occur on a rising edge where `in_valid` = 1 and `in_ready` = 1; an output handshake SHALL occur where `out_valid` = 1 and `out_ready` = 1.
REQ-005 On input handshake, the stage SHALL compute t = `in_state` XOR `in_key` (AddRoundKey).
REQ-006 If `in_last` = 0, the stored result SHALL be InvMixColumns(t); if `in_last` = 1, the stored result SHALL be t unchanged.
REQ-007 InvMixColumns SHALL multiply each column by the circulant matrix rows [0E 0B 0D 09], [09 0E 0B 0D], [0D 09 0E 0B], [0B 0D 09 0E] over GF(2^8), reduction polynomial 0x11B.
REQ-008 All arithmetic SHALL be computed combinationally on the input path and registered on acceptance; no arithmetic SHALL be performed on the output path.
REQ-009 Results SHALL be held in a 2-entry FIFO (entries 0 and 1, occupancy count 0..2), each entry holding {state[127:0], last}.
REQ-010 `out_state`/`out_last` SHALL always present the oldest entry; `out_valid` SHALL be 1 iff count > 0.
REQ-011 `in_ready` SHALL be 1 iff count < 2.
REQ-012 Latency SHALL be 1 cycle: a beat accepted at edge N with count = 0 SHALL give `out_valid` = 1 and the result on `out_state` after edge N.
REQ-013 Simultaneous input and output handshake SHALL leave count unchanged, pop the head, and append the new entry behind the remaining one.
REQ-014 With count = 2, no input handshake is possible (`in_ready` = 0); an output handshake SHALL take count to 1 and `in_ready` to 1 after that edge.
REQ-015 With count = 0, `out_ready` SHALL have no effect.
REQ-016 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.
REQ-017 `out_state`/`out_last` SHALL hold stable while `out_valid` = 1 and `out_ready` = 0.
REQ-018 `blk_cnt` SHALL increment by 1 on each output handshake and wrap from 0xFFFF to 0x0000.
REQ-019 Inputs SHALL be ignored when `in_ready` = 0 or `in_valid` = 0.

Reset
REQ-020 While `rst` = 1 at a rising edge, count, `blk_cnt` and all entry registers SHALL become 0.
REQ-021 After reset: `out_valid` = 0, `out_state` = 0, `out_last` = 0, `in_ready` = 1, `blk_cnt` = 0.
REQ-022 Reset SHALL take priority over any simultaneous handshake, and SHALL discard buffered beats mid-operation.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- **V1:** every column of `in_state` = 8e4da1bc, `in_key` = 0, `in_last` = 0, `out_ready` = 1 → one cycle later every column of `out_state` = db135345.
- **V2:** every column of `in_state` = 9fdc589d, `in_key` = 0, `in_last` = 0 → every column of `out_state` = f20a225c; repeated with `in_key` = every column 9fdc589d XOR 8e4da1bc, so every column of t = 8e4da1bc → every column of `out_state` = db135345.
- **V3:** `in_state` = 00112233445566778899aabbccddeeff, `in_key` = 000102030405060708090a0b0c0d0e0f, `in_last` = 1 → `out_state` = 00102030405060708090a0b0c0d0e0f0 and `out_last` = 1.
- **V4 (backpressure):** `out_ready` = 0, offer beats A, B, C → A and B accepted, `in_ready` = 0 with C held; raise `out_ready` → A, B, C emerge in order and `blk_cnt` = 3.
- **V5 (simultaneous push/pop):** count = 1 with `in_valid` = `out_ready` = 1 for 4 cycles → count stays 1 and order is preserved.
- **V6 (reset mid-operation):** count = 2, `blk_cnt` = 5, `rst` pulsed 1 cycle → `out_valid` = 0, `in_ready` = 1, `blk_cnt` = 0; no stale beat is emitted afterwards.

Source files
------------

// File: rtl/inv_addkey_mixcol_stage.sv
// AES decryption round tail: AddRoundKey then InvMixColumns (bypassed on
// the final round), buffered in a 2-entry FIFO with valid/ready handshakes.
module inv_addkey_mixcol_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last,
    output logic [15:0]  blk_cnt
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column times the inverse circulant [0E 0B 0D 09]; row 0 is the top byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] m2, m4, m8;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            m2    = xt(a[i]);
            m4    = xt(m2);
            m8    = xt(m4);
            m9[i] = m8 ^ a[i];
            mb[i] = m8 ^ m2 ^ a[i];
            md[i] = m8 ^ m4 ^ a[i];
            me[i] = m8 ^ m4 ^ m2;
        end
        r[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
        r[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
        r[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
        r[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        return r;
    endfunction

    logic [127:0] e0_state_q, e0_state_d;
    logic [127:0] e1_state_q, e1_state_d;
    logic         e0_last_q, e0_last_d;
    logic         e1_last_q, e1_last_d;
    logic [1:0]   count_q, count_d;
    logic [15:0]  blk_cnt_q, blk_cnt_d;
    logic [127:0] t;
    logic [127:0] mixed;
    logic [127:0] res;
    logic         push;
    logic         pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_state = e0_state_q;
    assign out_last  = e0_last_q;
    assign blk_cnt   = blk_cnt_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Round arithmetic on the input path, ready to be captured on acceptance.
    always_comb begin
        t     = in_state ^ in_key;
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
        end
        res = in_last ? t : mixed;
    end

    // FIFO next state: entry 0 is always the head, pops shift entry 1 down.
    always_comb begin
        e0_state_d = e0_state_q;
        e0_last_d  = e0_last_q;
        e1_state_d = e1_state_q;
        e1_last_d  = e1_last_q;
        count_d    = count_q;
        blk_cnt_d  = blk_cnt_q;
        if (pop) begin
            blk_cnt_d  = blk_cnt_q + 16'd1;
            e0_state_d = e1_state_q;
            e0_last_d  = e1_last_q;
        end
        if (push) begin
            if (count_q == 2'd0 || (pop && count_q == 2'd1)) begin
                e0_state_d = res;
                e0_last_d  = in_last;
            end else begin
                e1_state_d = res;
                e1_last_d  = in_last;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset that drops any buffered beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            e0_state_q <= '0;
            e0_last_q  <= 1'b0;
            e1_state_q <= '0;
            e1_last_q  <= 1'b0;
            count_q    <= 2'd0;
            blk_cnt_q  <= 16'd0;
        end else begin
            e0_state_q <= e0_state_d;
            e0_last_q  <= e0_last_d;
            e1_state_q <= e1_state_d;
            e1_last_q  <= e1_last_d;
            count_q    <= count_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

endmodule

// File: tb/tb_inv_addkey_mixcol_stage.sv
// Directed bench with a scoreboard: expected beats are queued on acceptance
// and compared against the DUT head on every output handshake.
module tb_inv_addkey_mixcol_stage;

    typedef struct packed {
        logic [127:0] st;
        logic         last;
    } beat_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_last;
    logic [15:0]  blk_cnt;

    int checks;
    int failures;
    beat_t sb[$];

    inv_addkey_mixcol_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_last  (out_last),
        .blk_cnt   (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift-and-add GF(2^8) multiply, reduction 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s,
                                           input logic [127:0] k,
                                           input logic last);
        logic [127:0] tt;
        logic [127:0] r;
        logic [7:0]   m [4][4];
        logic [7:0]   v;
        logic [7:0]   col [4];
        m[0] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        m[1] = '{8'h09, 8'h0e, 8'h0b, 8'h0d};
        m[2] = '{8'h0d, 8'h09, 8'h0e, 8'h0b};
        m[3] = '{8'h0b, 8'h0d, 8'h09, 8'h0e};
        tt = s ^ k;
        if (last) return tt;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) col[j] = tt[127-8*(4*c+j) -: 8];
            for (int row = 0; row < 4; row++) begin
                v = 8'h00;
                for (int j = 0; j < 4; j++) v = v ^ gmul(m[row][j], col[j]);
                r[127-8*(4*c+row) -: 8] = v;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on output handshake, push on input handshake.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 128'd1, 128'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_state", out_state, e.st);
                    check("sb_last", {127'd0, out_last}, {127'd0, e.last});
                end
            end
            if (in_valid && in_ready) begin
                e.st   = model(in_state, in_key, in_last);
                e.last = in_last;
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] s, input logic [127:0] k,
                         input logic last);
        in_valid = 1'b1;
        in_state = s;
        in_key   = k;
        in_last  = last;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        sb.delete();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] beat_a;
    int wait_cnt;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        do_reset();

        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_out_last", {127'd0, out_last}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_blk_cnt", {112'd0, blk_cnt}, 128'd0);

        // V1
        out_ready = 1'b1;
        drive({4{32'h8e4da1bc}}, '0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("v1_valid", {127'd0, out_valid}, 128'd1);
        check("v1_state", out_state, {4{32'hdb135345}});
        tick();
        check("v1_empty", {127'd0, out_valid}, 128'd0);

        // V2
        drive({4{32'h9fdc589d}}, '0, 1'b0);
        tick();
        check("v2a_state", out_state, {4{32'hf20a225c}});
        drive({4{32'h9fdc589d}}, {4{32'h9fdc589d ^ 32'h8e4da1bc}}, 1'b0);
        tick();
        in_valid = 1'b0;
        check("v2b_state", out_state, {4{32'hdb135345}});
        tick();

        // V3
        drive(128'h00112233445566778899aabbccddeeff,
              128'h000102030405060708090a0b0c0d0e0f, 1'b1);
        tick();
        in_valid = 1'b0;
        check("v3_state", out_state, 128'h00102030405060708090a0b0c0d0e0f0);
        check("v3_last", {127'd0, out_last}, 128'd1);
        tick();

        // V4
        do_reset();
        beat_a = rnd128();
        drive(beat_a, 128'h0, 1'b0);
        tick();
        drive(rnd128(), rnd128(), 1'b1);
        tick();
        drive(rnd128(), rnd128(), 1'b0);
        check("v4_full_ready", {127'd0, in_ready}, 128'd0);
        tick();
        tick();
        check("v4_hold_ready", {127'd0, in_ready}, 128'd0);
        check("v4_hold_state", out_state, model(beat_a, 128'h0, 1'b0));
        out_ready = 1'b1;
        tick();
        check("v4_pop_ready", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check("v4_blk_cnt", {112'd0, blk_cnt}, 128'd3);
        check("v4_empty", {127'd0, out_valid}, 128'd0);

        // V5
        out_ready = 1'b0;
        drive(rnd128(), rnd128(), 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(rnd128(), rnd128(), i[0]);
            tick();
            check("v5_valid", {127'd0, out_valid}, 128'd1);
            check("v5_ready", {127'd0, in_ready}, 128'd1);
        end
        in_valid = 1'b0;
        tick();
        check("v5_blk_cnt", {112'd0, blk_cnt}, 128'd8);

        // V6
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(rnd128(), rnd128(), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("v6_blk5", {112'd0, blk_cnt}, 128'd5);
        out_ready = 1'b0;
        drive(rnd128(), rnd128(), 1'b0);
        tick();
        drive(rnd128(), rnd128(), 1'b1);
        tick();
        check("v6_full", {127'd0, in_ready}, 128'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(rnd128(), rnd128(), 1'b0);
        tick();
        sb.delete();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("v6_valid", {127'd0, out_valid}, 128'd0);
        check("v6_ready", {127'd0, in_ready}, 128'd1);
        check("v6_blk0", {112'd0, blk_cnt}, 128'd0);
        check("v6_state0", out_state, 128'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("v6_no_stale", {127'd0, out_valid}, 128'd0);
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
